// File: rtl/dca_lsu_seq_pkg.sv
// Shared types for the DCA load/store row sequencers: FSM states, the row
// transaction record and the outstanding-counter width helper.
package dca_lsu_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } seq_state_t;

   localparam int MAX_OUTSTANDING_DEF = 4;
   localparam int BW_ADDR_DEF         = 32;
   localparam int BW_ROW_COUNT_DEF    = 8;

   localparam int BW_OUTSTANDING = $clog2(MAX_OUTSTANDING_DEF + 1);

   typedef struct packed {
      logic [BW_ADDR_DEF-1:0]      addr;
      logic [BW_ROW_COUNT_DEF-1:0] row;
   } row_txn_t;

   function automatic int outstanding_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/dca_credit_counter.sv
// Up/down credit counter: saturates at MAX_COUNT, holds at zero, and flags a
// decrement that arrives while the count is zero.
module dca_credit_counter #(
   parameter int BW_COUNT  = 3,
   parameter int MAX_COUNT = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clr,
   input  logic                i_inc,
   input  logic                i_dec,
   output logic [BW_COUNT-1:0] o_count,
   output logic                o_at_cap,
   output logic                o_underflow
);

   localparam logic [BW_COUNT-1:0] CAP = BW_COUNT'(MAX_COUNT);

   logic [BW_COUNT-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= '0;
      end else if (i_inc && !i_dec && (r_count != CAP)) begin
         r_count <= r_count + BW_COUNT'(1);
      end else if (i_dec && !i_inc && (r_count != '0)) begin
         r_count <= r_count - BW_COUNT'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count     = r_count;
   assign o_at_cap    = (r_count >= CAP);
   assign o_underflow = i_dec && (r_count == '0);

endmodule

// File: rtl/dca_matrix_load_sequencer.sv
// Splits a tile-load command into one LSU transaction per row, caps the
// number in flight, and reports done/aborted/err once the rows come back.
module dca_matrix_load_sequencer
   import dca_lsu_seq_pkg::*;
#(
   parameter int BW_ADDR         = 32,
   parameter int BW_STRIDE       = 16,
   parameter int BW_ROW_COUNT    = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic [BW_ADDR-1:0]      i_cmd_addr,
   input  logic [BW_STRIDE-1:0]    i_cmd_stride,
   input  logic [BW_ROW_COUNT-1:0] i_cmd_num_rows,
   input  logic                    i_abort,
   output logic                    o_txn_valid,
   input  logic                    i_txn_ready,
   output logic [BW_ADDR-1:0]      o_txn_addr,
   output logic [BW_ROW_COUNT-1:0] o_txn_row,
   input  logic                    i_row_done,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_aborted,
   output logic                    o_err
);

   localparam int BW_OUT = outstanding_width(MAX_OUTSTANDING);

   seq_state_t              r_state;
   seq_state_t              w_next_state;
   logic [BW_STRIDE-1:0]    r_stride;
   logic [BW_ROW_COUNT-1:0] r_num_rows;
   logic [BW_ADDR-1:0]      r_txn_addr;
   logic [BW_ROW_COUNT-1:0] r_txn_row;
   logic                    r_abort_pend;
   logic                    r_aborted;
   logic                    r_err;

   logic                    w_cmd_ready;
   logic                    w_txn_valid;
   logic                    w_busy;
   logic                    w_done;
   logic                    w_accept;
   logic                    w_txn_hs;
   logic                    w_last_issue;
   logic                    w_abort_now;
   logic [BW_OUT-1:0]       w_count;
   logic                    w_at_cap;
   logic                    w_underflow;

   assign w_accept     = w_cmd_ready && i_cmd_valid;
   assign w_txn_hs     = w_txn_valid && i_txn_ready;
   assign w_last_issue = w_txn_hs && ((r_txn_row + BW_ROW_COUNT'(1)) == r_num_rows);
   // A stalled offer is never withdrawn: abort only lands once the offer is gone or accepted.
   assign w_abort_now  = (i_abort || r_abort_pend) && (!w_txn_valid || i_txn_ready);

   dca_credit_counter #(
      .BW_COUNT  (BW_OUT),
      .MAX_COUNT (MAX_OUTSTANDING)
   ) u_credit (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (w_accept),
      .i_inc       (w_txn_hs),
      .i_dec       (i_row_done),
      .o_count     (w_count),
      .o_at_cap    (w_at_cap),
      .o_underflow (w_underflow)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next_state = (i_cmd_num_rows == '0) ? S_DONE : S_ISSUE;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (w_last_issue || w_abort_now) begin
               w_next_state = S_DRAIN;
            end else begin
               w_next_state = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if ((w_count == BW_OUT'(0)) || ((w_count == BW_OUT'(1)) && i_row_done)) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_DRAIN;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_cmd_ready = 1'b0;
      w_txn_valid = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE:  w_cmd_ready = 1'b1;
         S_ISSUE: begin
            w_busy      = 1'b1;
            w_txn_valid = (r_txn_row < r_num_rows) && !w_at_cap;
         end
         S_DRAIN: w_busy = 1'b1;
         S_DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: w_busy = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stride   <= '0;
         r_num_rows <= '0;
         r_txn_addr <= '0;
         r_txn_row  <= '0;
      end else if (w_accept) begin
         r_stride   <= i_cmd_stride;
         r_num_rows <= i_cmd_num_rows;
         r_txn_addr <= i_cmd_addr;
         r_txn_row  <= '0;
      end else if (w_txn_hs) begin
         r_txn_addr <= r_txn_addr + BW_ADDR'(r_stride);
         r_txn_row  <= r_txn_row + BW_ROW_COUNT'(1);
      end else begin
         r_txn_addr <= r_txn_addr;
         r_txn_row  <= r_txn_row;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || w_accept) begin
         r_abort_pend <= 1'b0;
         r_aborted    <= 1'b0;
      end else if (r_state == S_ISSUE) begin
         r_abort_pend <= r_abort_pend || (i_abort && w_txn_valid && !i_txn_ready);
         r_aborted    <= r_aborted || w_abort_now;
      end else begin
         r_abort_pend <= r_abort_pend;
         r_aborted    <= r_aborted;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || w_accept) begin
         r_err <= 1'b0;
      end else if (w_underflow) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

   assign o_cmd_ready = w_cmd_ready;
   assign o_txn_valid = w_txn_valid;
   assign o_txn_addr  = r_txn_addr;
   assign o_txn_row   = r_txn_row;
   assign o_busy      = w_busy;
   assign o_done      = w_done;
   assign o_aborted   = r_aborted;
   assign o_err       = r_err;

endmodule

// File: tb/tb_dca_matrix_load_sequencer.sv
// Bench for dca_matrix_load_sequencer: command table plus hand-written cap,
// abort, spurious row_done and mid-command reset sequences.
module tb_dca_matrix_load_sequencer;

   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, abort, txn_valid, txn_ready, row_done;
   logic        busy, done, aborted, err;
   logic [31:0] cmd_addr, txn_addr;
   logic [15:0] cmd_stride;
   logic [7:0]  cmd_num_rows, txn_row;

   always #5 clk = ~clk;

   dca_matrix_load_sequencer #(
      .BW_ADDR(32), .BW_STRIDE(16), .BW_ROW_COUNT(8), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_addr(cmd_addr), .i_cmd_stride(cmd_stride), .i_cmd_num_rows(cmd_num_rows),
      .i_abort(abort), .o_txn_valid(txn_valid), .i_txn_ready(txn_ready),
      .o_txn_addr(txn_addr), .o_txn_row(txn_row), .i_row_done(row_done),
      .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_err(err)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  row;
   } txn_t;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] stride;
      logic [7:0]  rows;
      int          delay;
      bit          rand_ready;
      int          exp_txns;
      logic [31:0] exp_last_addr;
   } vec_t;

   txn_t        exp_q[$];
   int          rd_due[$];
   vec_t        vecs[6];
   int          cyc, n_checks, n_errors, hs_cnt, rd_cnt, model_out, last_rd_cyc;
   bit          auto_rd, rand_ready;
   int          rd_delay;
   logic        prev_stall;
   logic [31:0] prev_addr, last_hs_addr;
   logic [7:0]  prev_row;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // One clock: score the handshake/row_done of the current cycle, then advance.
   task automatic step();
      txn_t e;
      logic hs;
      logic rd;
      hs = txn_valid && txn_ready;
      rd = row_done;
      if (model_out >= MAXO) check("cap_valid_low", 32'(txn_valid), 32'd0);
      if (prev_stall) begin
         check("hold_valid", 32'(txn_valid), 32'd1);
         check("hold_addr", txn_addr, prev_addr);
         check("hold_row", 32'(txn_row), 32'(prev_row));
      end
      if (hs) begin
         hs_cnt++;
         last_hs_addr = txn_addr;
         if (exp_q.size() == 0) begin
            fail_now("unexpected_txn");
         end else begin
            e = exp_q.pop_front();
            check("txn_addr", txn_addr, e.addr);
            check("txn_row", 32'(txn_row), 32'(e.row));
         end
         if (auto_rd) rd_due.push_back(cyc + rd_delay);
      end
      if (rd) begin
         rd_cnt++;
         last_rd_cyc = cyc;
      end
      if (hs && !rd) model_out++;
      else if (rd && !hs && model_out > 0) model_out--;
      prev_stall = txn_valid && !txn_ready;
      prev_addr  = txn_addr;
      prev_row   = txn_row;
      @(posedge clk);
      #1;
      cyc++;
      row_done = 1'b0;
      if (auto_rd && rd_due.size() > 0 && rd_due[0] == cyc) begin
         void'(rd_due.pop_front());
         row_done = 1'b1;
      end
      if (rand_ready) txn_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic check_reset_outputs();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_txn_valid", 32'(txn_valid), 32'd0);
      check("rst_txn_addr", txn_addr, 32'd0);
      check("rst_txn_row", 32'(txn_row), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);
      check("rst_err", 32'(err), 32'd0);
   endtask

   task automatic push_expected(input logic [31:0] base, input logic [15:0] stride, input int n);
      logic [31:0] a;
      a = base;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{addr: a, row: 8'(i)});
         a = a + 32'(stride);
      end
   endtask

   task automatic accept_cmd(input logic [31:0] a, input logic [15:0] s, input logic [7:0] n);
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      hs_cnt       = 0;
      rd_cnt       = 0;
      cmd_valid    = 1'b1;
      cmd_addr     = a;
      cmd_stride   = s;
      cmd_num_rows = n;
      step();
      cmd_valid = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      check("err_cleared", 32'(err), 32'd0);
      check("aborted_cleared", 32'(aborted), 32'd0);
   endtask

   task automatic wait_done(output bit seen);
      int w;
      w = 0;
      while (!done && w < 300) begin
         step();
         w++;
      end
      seen = done;
      if (!seen) fail_now("done_timeout");
   endtask

   task automatic finish_cmd(input int exp_txns, input logic exp_ab);
      check("done_latency", 32'(cyc), 32'(last_rd_cyc + 1));
      check("aborted_flag", 32'(aborted), 32'(exp_ab));
      check("err_flag", 32'(err), 32'd0);
      check("txn_count", 32'(hs_cnt), 32'(exp_txns));
      check("row_done_count", 32'(rd_cnt), 32'(exp_txns));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
      step();
      check("done_one_cycle", 32'(done), 32'd0);
      check("cmd_ready_back", 32'(cmd_ready), 32'd1);
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int  n;
      bit  seen;
      push_expected(v.addr, v.stride, v.exp_txns);
      auto_rd    = 1'b1;
      rd_delay   = v.delay;
      rand_ready = v.rand_ready;
      txn_ready  = 1'b1;
      n = cyc;
      accept_cmd(v.addr, v.stride, v.rows);
      check("first_txn_valid", 32'(txn_valid), 32'(v.rows != 8'd0));
      wait_done(seen);
      rand_ready = 1'b0;
      txn_ready  = 1'b1;
      if (seen) begin
         if (v.exp_txns == 0) begin
            check("zero_rows_done_lat", 32'(cyc), 32'(n + 1));
            check("zero_rows_no_txn", 32'(hs_cnt), 32'd0);
            check("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
            step();
            check("zero_rows_cmd_ready", 32'(cmd_ready), 32'd1);
            check("done_one_cycle", 32'(done), 32'd0);
         end else begin
            check("last_txn_addr", last_hs_addr, v.exp_last_addr);
            finish_cmd(v.exp_txns, 1'b0);
         end
      end
   endtask

   initial begin
      bit seen;
      int w;
      vecs[0] = '{32'h0000_1000, 16'h0040, 8'd3, 2, 1'b0, 3, 32'h0000_1080};
      vecs[1] = '{32'hFFFF_FFC0, 16'h0040, 8'd2, 1, 1'b0, 2, 32'h0000_0000};
      vecs[2] = '{32'h0000_4000, 16'h0080, 8'd0, 2, 1'b0, 0, 32'h0000_0000};
      vecs[3] = '{32'h0000_2000, 16'h0010, 8'd8, 6, 1'b0, 8, 32'h0000_2070};
      vecs[4] = '{32'h0000_3000, 16'h0100, 8'd5, 3, 1'b1, 5, 32'h0000_3400};
      vecs[5] = '{32'h0000_FFF0, 16'hFFFF, 8'd3, 1, 1'b0, 3, 32'h0002_FFEE};

      n_checks = 0; n_errors = 0; cyc = 0; model_out = 0; hs_cnt = 0; rd_cnt = 0;
      last_rd_cyc = 0; auto_rd = 1'b0; rand_ready = 1'b0; rd_delay = 1;
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_stride = 16'd0;
      cmd_num_rows = 8'd0; abort = 1'b0; txn_ready = 1'b1; row_done = 1'b0;
      prev_stall = 1'b0; prev_addr = 32'd0; prev_row = 8'd0; last_hs_addr = 32'd0;
      step(); step(); step();
      rst = 1'b0;
      prev_stall = 1'b0;
      check_reset_outputs();

      // Spurious row_done in IDLE sets err; the next accept clears it.
      row_done = 1'b1;
      step();
      check("spurious_err", 32'(err), 32'd1);
      check("spurious_busy", 32'(busy), 32'd0);
      check("spurious_cmd_ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Outstanding cap with manually timed row_done.
      auto_rd = 1'b0;
      txn_ready = 1'b1;
      push_expected(32'h0000_2000, 16'h0010, 8);
      accept_cmd(32'h0000_2000, 16'h0010, 8'd8);
      w = 0;
      while (hs_cnt < 4 && w < 20) begin step(); w++; end
      check("cap_stop_valid", 32'(txn_valid), 32'd0);
      check("cap_stop_row", 32'(txn_row), 32'd4);
      check("cap_stop_addr", txn_addr, 32'h0000_2040);
      step();
      check("cap_still_low", 32'(txn_valid), 32'd0);
      row_done = 1'b1;
      step();
      check("cap_resume", 32'(txn_valid), 32'd1);
      row_done = 1'b1;
      step();
      check("cap_hs_and_rd", 32'(txn_valid), 32'd1);
      check("cap_hs_and_rd_row", 32'(txn_row), 32'd5);
      step();
      check("cap_again", 32'(txn_valid), 32'd0);
      w = 0;
      while (!done && w < 100) begin
         row_done = (model_out > 0);
         step();
         w++;
      end
      if (!done) fail_now("cap_done_timeout");
      else finish_cmd(8, 1'b0);

      // Abort while row 2 is stalled.
      auto_rd  = 1'b1;
      rd_delay = 8;
      txn_ready = 1'b1;
      push_expected(32'h0000_5000, 16'h0020, 3);
      accept_cmd(32'h0000_5000, 16'h0020, 8'd10);
      w = 0;
      while (!(txn_valid && txn_row == 8'd2) && w < 20) begin step(); w++; end
      txn_ready = 1'b0;
      abort = 1'b1;
      check("abort_row", 32'(txn_row), 32'd2);
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_hold_valid", 32'(txn_valid), 32'd1);
         check("abort_hold_addr", txn_addr, 32'h0000_5040);
      end
      txn_ready = 1'b1;
      step();
      abort = 1'b0;
      check("abort_stop", 32'(txn_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd1);
      wait_done(seen);
      if (seen) finish_cmd(3, 1'b1);

      run_vec(vecs[0]);

      // Reset in the middle of ISSUE.
      rd_delay = 3;
      txn_ready = 1'b1;
      push_expected(32'h0000_7000, 16'h0004, 6);
      accept_cmd(32'h0000_7000, 16'h0004, 8'd6);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs();
      exp_q.delete();
      rd_due.delete();
      model_out = 0;
      prev_stall = 1'b0;
      row_done = 1'b0;

      run_vec(vecs[1]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
